// File: rtl/id_pipe_pkg.sv
// id_pipe_pkg: shared decode constants for the ID stage.
//   Opcode and funct field codes, EXE_*_OP aluop codes, EXE_RES_* alusel
//   codes, the zero word, the NOP write address and the read/write enable
//   levels.
package id_pipe_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;

  localparam logic [7:0] EXE_NOP_OP = 8'h00;
  localparam logic [7:0] EXE_AND_OP = 8'h24;
  localparam logic [7:0] EXE_OR_OP  = 8'h25;
  localparam logic [7:0] EXE_XOR_OP = 8'h26;
  localparam logic [7:0] EXE_NOR_OP = 8'h27;
  localparam logic [7:0] EXE_SLL_OP = 8'h7C;
  localparam logic [7:0] EXE_SRL_OP = 8'h02;
  localparam logic [7:0] EXE_SRA_OP = 8'h03;

  localparam logic [2:0] EXE_RES_NOP   = 3'd0;
  localparam logic [2:0] EXE_RES_LOGIC = 3'd1;
  localparam logic [2:0] EXE_RES_SHIFT = 3'd2;

  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
  localparam logic        READ_ENABLE   = 1'b1;
  localparam logic        READ_DISABLE  = 1'b0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/id_pipe_if.sv
// id_pipe_if: ID/EX output slot bundle.
//   out_valid / out_ready handshake plus the registered decode results
//   (pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, inst_invalid_o).
//   master = ID stage (drives the slot), slave = EX stage (consumes it).
interface id_pipe_if #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
);
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   pc_o;
  logic [ALUOP_W-1:0]  aluop_o;
  logic [ALUSEL_W-1:0] alusel_o;
  logic [DATA_W-1:0]   reg1_o;
  logic [DATA_W-1:0]   reg2_o;
  logic [REG_AW-1:0]   wd_o;
  logic                wreg_o;
  logic                inst_invalid_o;

  modport master (
    output out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, inst_invalid_o,
    input  out_ready
  );

  modport slave (
    input  out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, inst_invalid_o,
    output out_ready
  );
endinterface

// File: rtl/id_decode.sv
// id_decode: purely combinational instruction decoder.
//   in : inst (32-bit instruction word)
//   out: aluop, alusel, re1/re2 (port read enables), wd/wreg (destination),
//        imm1/imm2 (value a disabled read port takes), invalid.
// Each read port has its own immediate: shifts put shamt on port 1, LUI puts
// zero on port 1 and imm16<<16 on port 2, I-type logic ops zero-extend on port 2.
module id_decode
  import id_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic [31:0]         inst,
  output logic [ALUOP_W-1:0]  aluop,
  output logic [ALUSEL_W-1:0] alusel,
  output logic                re1,
  output logic                re2,
  output logic [REG_AW-1:0]   wd,
  output logic                wreg,
  output logic [DATA_W-1:0]   imm1,
  output logic [DATA_W-1:0]   imm2,
  output logic                invalid
);
  logic [5:0] op;
  logic [5:0] funct;
  logic       is_itype;
  logic       is_rtype;
  logic       is_shift;

  assign op    = inst[31:26];
  assign funct = inst[5:0];

  always_comb begin
    aluop    = ALUOP_W'(EXE_NOP_OP);
    alusel   = ALUSEL_W'(EXE_RES_NOP);
    re1      = READ_DISABLE;
    re2      = READ_DISABLE;
    wd       = REG_AW'(NOP_REG_ADDR);
    wreg     = WRITE_DISABLE;
    imm1     = DATA_W'(ZERO_WORD);
    imm2     = DATA_W'(ZERO_WORD);
    invalid  = 1'b1;
    is_itype = 1'b0;
    is_rtype = 1'b0;
    is_shift = 1'b0;

    case (op)
      OP_ANDI: begin is_itype = 1'b1; aluop = ALUOP_W'(EXE_AND_OP); end
      OP_ORI:  begin is_itype = 1'b1; aluop = ALUOP_W'(EXE_OR_OP);  end
      OP_XORI: begin is_itype = 1'b1; aluop = ALUOP_W'(EXE_XOR_OP); end
      OP_LUI: begin
        // LUI executes as OR of zero with the shifted immediate
        aluop   = ALUOP_W'(EXE_OR_OP);
        alusel  = ALUSEL_W'(EXE_RES_LOGIC);
        wd      = REG_AW'(inst[20:16]);
        wreg    = WRITE_ENABLE;
        imm2    = DATA_W'({inst[15:0], 16'h0000});
        invalid = 1'b0;
      end
      OP_SPECIAL: begin
        case (funct)
          FUNCT_AND: begin is_rtype = 1'b1; aluop = ALUOP_W'(EXE_AND_OP); end
          FUNCT_OR:  begin is_rtype = 1'b1; aluop = ALUOP_W'(EXE_OR_OP);  end
          FUNCT_XOR: begin is_rtype = 1'b1; aluop = ALUOP_W'(EXE_XOR_OP); end
          FUNCT_NOR: begin is_rtype = 1'b1; aluop = ALUOP_W'(EXE_NOR_OP); end
          FUNCT_SLL: begin is_shift = 1'b1; aluop = ALUOP_W'(EXE_SLL_OP); end
          FUNCT_SRL: begin is_shift = 1'b1; aluop = ALUOP_W'(EXE_SRL_OP); end
          FUNCT_SRA: begin is_shift = 1'b1; aluop = ALUOP_W'(EXE_SRA_OP); end
          default: ;
        endcase
      end
      default: ;
    endcase

    if (is_itype) begin
      alusel  = ALUSEL_W'(EXE_RES_LOGIC);
      re1     = READ_ENABLE;
      wd      = REG_AW'(inst[20:16]);
      wreg    = WRITE_ENABLE;
      imm2    = DATA_W'({16'h0000, inst[15:0]});
      invalid = 1'b0;
    end
    if (is_rtype) begin
      alusel  = ALUSEL_W'(EXE_RES_LOGIC);
      re1     = READ_ENABLE;
      re2     = READ_ENABLE;
      wd      = REG_AW'(inst[15:11]);
      wreg    = WRITE_ENABLE;
      invalid = 1'b0;
    end
    if (is_shift) begin
      alusel  = ALUSEL_W'(EXE_RES_SHIFT);
      re2     = READ_ENABLE;
      wd      = REG_AW'(inst[15:11]);
      wreg    = WRITE_ENABLE;
      imm1    = DATA_W'(inst[10:6]);
      invalid = 1'b0;
    end
  end
endmodule

// File: rtl/id_pipe.sv
// id_pipe: decode stage with a registered ID/EX slot.
//   clk, rst (async, active-low)
//   fetch side : in_valid, in_ready, pc_i, inst_i
//   regfile    : reg1/2_re_o, reg1/2_addr_o, reg1/2_data_i
//   producers  : ex_wreg_i, ex_wd_i, ex_wdata_i, ex_wdata_vld_i,
//                mem_wreg_i, mem_wd_i, mem_wdata_i
//   flush_i    : drop slot and current input
//   slot       : id_pipe_if.master (out_valid/out_ready + decode results)
// Build option ID_FWD_EN: when defined, operands are forwarded from EX/MEM and
// only an EX result not yet valid stalls; when undefined, any EX/MEM hazard
// stalls and operands come from the regfile/immediate only.
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [31:0]       inst_i,
  output logic              reg1_re_o,
  output logic              reg2_re_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_wdata_vld_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              flush_i,
  id_pipe_if.master         slot
);
  logic [ALUOP_W-1:0]  dec_aluop;
  logic [ALUSEL_W-1:0] dec_alusel;
  logic                dec_re1, dec_re2, dec_wreg, dec_invalid;
  logic [REG_AW-1:0]   dec_wd;
  logic [DATA_W-1:0]   dec_imm1, dec_imm2;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, stall, accept;
  logic [DATA_W-1:0] op1, op2;

  logic                out_valid_q, wreg_q, invalid_q;
  logic [DATA_W-1:0]   pc_q, reg1_q, reg2_q;
  logic [ALUOP_W-1:0]  aluop_q;
  logic [ALUSEL_W-1:0] alusel_q;
  logic [REG_AW-1:0]   wd_q;

  id_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)) u_decode (
    .inst(inst_i), .aluop(dec_aluop), .alusel(dec_alusel), .re1(dec_re1), .re2(dec_re2),
    .wd(dec_wd), .wreg(dec_wreg), .imm1(dec_imm1), .imm2(dec_imm2), .invalid(dec_invalid)
  );

  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);
  assign reg1_re_o   = in_valid && dec_re1;
  assign reg2_re_o   = in_valid && dec_re2;

  // $0 is hardwired zero, so it never matches a producer
  assign ex_hit1  = ex_wreg_i  && (ex_wd_i  == reg1_addr_o) && (reg1_addr_o != '0);
  assign ex_hit2  = ex_wreg_i  && (ex_wd_i  == reg2_addr_o) && (reg2_addr_o != '0);
  assign mem_hit1 = mem_wreg_i && (mem_wd_i == reg1_addr_o) && (reg1_addr_o != '0);
  assign mem_hit2 = mem_wreg_i && (mem_wd_i == reg2_addr_o) && (reg2_addr_o != '0);

`ifdef ID_FWD_EN
  assign stall = (reg1_re_o && ex_hit1 && !ex_wdata_vld_i) ||
                 (reg2_re_o && ex_hit2 && !ex_wdata_vld_i);

  always_comb begin
    op1 = dec_imm1;
    op2 = dec_imm2;
    if (dec_re1) begin
      if (reg1_addr_o == '0) op1 = '0;
      else if (ex_hit1)      op1 = ex_wdata_i;
      else if (mem_hit1)     op1 = mem_wdata_i;
      else                   op1 = reg1_data_i;
    end
    if (dec_re2) begin
      if (reg2_addr_o == '0) op2 = '0;
      else if (ex_hit2)      op2 = ex_wdata_i;
      else if (mem_hit2)     op2 = mem_wdata_i;
      else                   op2 = reg2_data_i;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_wdata_i, ex_wdata_vld_i, mem_wdata_i};

  // without bypass paths the instruction waits until the producer has retired
  assign stall = (reg1_re_o && (ex_hit1 || mem_hit1)) ||
                 (reg2_re_o && (ex_hit2 || mem_hit2));

  always_comb begin
    op1 = dec_imm1;
    op2 = dec_imm2;
    if (dec_re1) op1 = (reg1_addr_o == '0) ? '0 : reg1_data_i;
    if (dec_re2) op2 = (reg2_addr_o == '0) ? '0 : reg2_data_i;
  end
`endif

  assign in_ready = flush_i || (!stall && (!out_valid_q || slot.out_ready));
  assign accept   = !flush_i && in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      aluop_q     <= ALUOP_W'(EXE_NOP_OP);
      alusel_q    <= ALUSEL_W'(EXE_RES_NOP);
      reg1_q      <= '0;
      reg2_q      <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      invalid_q   <= 1'b0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      pc_q        <= pc_i;
      aluop_q     <= dec_aluop;
      alusel_q    <= dec_alusel;
      reg1_q      <= op1;
      reg2_q      <= op2;
      wd_q        <= dec_wd;
      wreg_q      <= dec_wreg;
      invalid_q   <= dec_invalid;
    end else if (slot.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign slot.out_valid      = out_valid_q;
  assign slot.pc_o           = pc_q;
  assign slot.aluop_o        = aluop_q;
  assign slot.alusel_o       = alusel_q;
  assign slot.reg1_o         = reg1_q;
  assign slot.reg2_o         = reg2_q;
  assign slot.wd_o           = wd_q;
  assign slot.wreg_o         = wreg_q;
  assign slot.inst_invalid_o = invalid_q;
endmodule

// File: doc/id_pipe.md
# id_pipe

Parametrised decode stage with a registered ID/EX output slot, valid/ready handshake, operand forwarding from EX and MEM, and interlock stall. It sits between instruction fetch and the execute unit. It decodes the instruction, reads the register file, and selects operands from forwarded results, immediates or register data. The result is held in an output pipeline register so that back-pressure from EX propagates cleanly to fetch.

## Interface
Parameters:
- DATA_W, 32, datapath/register width
- REG_AW, 5, register-file address width
- ALUOP_W, 8, aluop code width
- ALUSEL_W, 3, alusel code width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  fetch presents pc_i/inst_i
- in_ready  out  1  stage accepts the instruction this cycle
- pc_i  in  DATA_W  instruction address
- inst_i  in  32  instruction word
- reg1_re_o / reg2_re_o  out  1  register-file read enables (combinational)
- reg1_addr_o / reg2_addr_o  out  REG_AW  read addresses, inst_i[25:21] / inst_i[20:16]
- reg1_data_i / reg2_data_i  in  DATA_W  register-file read data (same cycle)
- ex_wreg_i, ex_wd_i, ex_wdata_i, ex_wdata_vld_i  in  1/REG_AW/DATA_W/1  EX-stage producer; vld low means result not yet available
- mem_wreg_i, mem_wd_i, mem_wdata_i  in  1/REG_AW/DATA_W  MEM-stage producer
- flush_i  in  1  discard slot and current input
- out_valid  out  1  ID/EX slot holds an instruction
- out_ready  in  1  EX consumes the slot
- pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, inst_invalid_o  out  registered decode results

## Operation
- Decoded opcodes: ORI 0x0D, ANDI 0x0C, XORI 0x0E (zero-extended imm16); LUI 0x0F (imm16<<16, reg1 = zero).
- SPECIAL 0x00 functs: AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLL 0x00, SRL 0x02, SRA 0x03.
- Immediate-type instructions: wd = rt, rs read, reg2 = imm.
- R-type instructions: wd = rd, rs and rt read.
- Shift instructions: reg1 = zero-extended shamt, reg2 = rt, rs not read.
- Any other encoding: inst_invalid_o = 1, wreg_o = 0, aluop = NOP. The slot still passes.
- Operand priority per read port:
  - address 0 reads zero, never forwarded;
  - otherwise EX match (ex_wreg_i, ex_wd_i == addr);
  - otherwise MEM match;
  - otherwise regfile data.
- A disabled read port takes the immediate; this is zero if the instruction has no immediate.
- stall = in_valid and an enabled read port matches EX with ex_wdata_vld_i = 0.
- in_ready = !stall && (!out_valid || out_ready). flush_i forces in_ready = 1.
- Slot load on edge:
  - flush_i: out_valid <= 0, input dropped;
  - else if in_valid && in_ready: load slot, out_valid <= 1;
  - else if out_ready: out_valid <= 0 (bubble).
  - Otherwise the slot holds unchanged.

## Timing
- Latency: one cycle from accept to out_valid.
- Throughput: one instruction per cycle when out_ready stays high.
- Reset: every registered output is 0, including out_valid, wreg_o, inst_invalid_o, aluop_o (EXE_NOP_OP) and alusel_o (EXE_RES_NOP). Reset asserted mid-operation clears immediately.
- Stall combined with a free slot inserts exactly one bubble per stalled cycle. Stall never drops or duplicates an instruction.
- Held slot: outputs are stable while out_valid && !out_ready.
- flush_i and a simultaneous accept: flush wins.
- in_valid low: rd-enables low, no stall.

## Configuration
- ID_FWD_EN defined: forwarding as above.
- ID_FWD_EN undefined: no forwarding. Any enabled-port match against EX or MEM (wreg set, nonzero address) stalls until the producer leaves MEM. Operands then come only from the regfile/immediate. ex_wdata_vld_i is ignored.

## Structure
- Shared define header holds: opcode/funct codes, EXE_*_OP aluop codes, EXE_RES_* alusel codes, ZeroWord, NOPRegAddr, ReadEnable/WriteEnable levels.
- One combinational sub-module, id_decode: inst → aluop, alusel, re1/re2, wd, wreg, imm, invalid.
- id_pipe owns forwarding, stall, handshake and slot register.

## Test plan
- ORI $3,$1,0x00FF with reg1_data_i=0x12340000, no producers → next cycle out_valid=1, reg1_o=0x12340000, reg2_o=0x000000FF, wd_o=3, wreg_o=1.
- OR $5,$1,$2 with EX writing $1=0xAAAA0000 and MEM writing $2=0x5555: reg1_o=0xAAAA0000, reg2_o=0x5555. If EX and MEM both write $1, EX value wins.
- EX writes $1 with ex_wdata_vld_i=0 for 2 cycles, instruction reads $1 → in_ready=0 for 2 cycles, 2 bubbles, then correct operand.
- out_ready=0 for 3 cycles with slot full → outputs unchanged, in_ready=0; out_ready=1 → back-to-back accept.
- Opcode 0x3F → inst_invalid_o=1, wreg_o=0. flush_i with in_valid → out_valid=0 next cycle.
- rst low mid-stream → all outputs 0 asynchronously. With ID_FWD_EN undefined, scenario 2 stalls instead of forwarding.
